// File: rtl/sign_cmp_pkg.sv
// Shared definitions for the bit-serial signed compare-and-select stage.
//   state_e      : controller states
//   DefaultWidth : default operand width
//   ref_lteq()   : flat reference for signed a <= b at the default width
package sign_cmp_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Word-level signed compare, used as the golden function for checking.
  function automatic logic ref_lteq(input logic [DefaultWidth-1:0] a,
                                    input logic [DefaultWidth-1:0] b);
    return $signed(a) <= $signed(b);
  endfunction

endpackage

// File: rtl/sign_lteq_bitcell.sv
// One step of the LSB-first signed <= recurrence.
//   ai, bi  : current bits of a and b
//   le      : running "a <= b" flag over the bits seen so far
//   is_sign : high when ai/bi are the sign bits
//   le_next : updated flag
// When the bits differ the flag is overwritten by x, which is bi on magnitude
// bits (a has 0, b has 1) and ai on the sign bit (a negative, b not). The
// select on is_sign is a control mux; the data path uses a single AND.
module sign_lteq_bitcell (
  input  logic ai,
  input  logic bi,
  input  logic le,
  input  logic is_sign,
  output logic le_next
);

  logic x;

  always_comb begin
    x       = is_sign ? ai : bi;
    le_next = le ^ ((ai ^ bi) & (x ^ le));
  end

endmodule

// File: rtl/sign_lteq_minmax_serial.sv
// Bit-serial signed compare-and-select: accepts one (a, b) pair, scans it
// LSB-first over WIDTH cycles and presents lteq = (a <= b), min and max.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake, in_a/in_b sampled on accept
//   out_valid/out_ready  : result handshake
//   out_lteq/min/max     : result, held until the next result is produced
module sign_lteq_minmax_serial
  import sign_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_lteq,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             le_q, le_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] a_hold_q, a_hold_d;
  logic [WIDTH-1:0] b_hold_q, b_hold_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_lteq_q, out_lteq_d;
  logic [WIDTH-1:0] out_min_q, out_min_d;
  logic [WIDTH-1:0] out_max_q, out_max_d;

  logic is_sign;
  logic le_next;

  assign is_sign = (cnt_q == LastCnt);

  sign_lteq_bitcell u_bitcell (
    .ai      (a_sh_q[0]),
    .bi      (b_sh_q[0]),
    .le      (le_q),
    .is_sign (is_sign),
    .le_next (le_next)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    le_d        = le_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    a_hold_d    = a_hold_q;
    b_hold_d    = b_hold_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_lteq_d  = out_lteq_q;
    out_min_d   = out_min_q;
    out_max_d   = out_max_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          a_sh_d     = in_a;
          b_sh_d     = in_b;
          a_hold_d   = in_a;
          b_hold_d   = in_b;
          le_d       = 1'b1;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = StShift;
        end
      end
      StShift: begin
        le_d   = le_next;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        if (is_sign) begin
          out_lteq_d  = le_next;
          out_min_d   = le_next ? a_hold_q : b_hold_q;
          out_max_d   = le_next ? b_hold_q : a_hold_q;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d     = StIdle;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      le_q        <= 1'b1;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      a_hold_q    <= '0;
      b_hold_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_lteq_q  <= 1'b0;
      out_min_q   <= '0;
      out_max_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      le_q        <= le_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      a_hold_q    <= a_hold_d;
      b_hold_q    <= b_hold_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_lteq_q  <= out_lteq_d;
      out_min_q   <= out_min_d;
      out_max_q   <= out_max_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_lteq  = out_lteq_q;
  assign out_min   = out_min_q;
  assign out_max   = out_max_q;

endmodule

// File: tb/tb_sign_lteq_minmax_serial.sv
module tb_sign_lteq_minmax_serial;
  import sign_cmp_pkg::*;

  localparam int unsigned W = 32;
  localparam int TimeoutCycles = 200;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic         out_lteq;
  logic [W-1:0] out_min;
  logic [W-1:0] out_max;

  int n_vec;
  int n_miss;

  sign_lteq_minmax_serial #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lteq  (out_lteq),
    .out_min   (out_min),
    .out_max   (out_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, then hands over one pair; returns after the accept edge.
  task automatic accept_pair(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    while (!in_ready && n < TimeoutCycles) begin
      tick();
      n++;
    end
    chk({tag, "_ready_wait"}, {31'd0, in_ready}, 1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < TimeoutCycles) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_pair(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic exp_l, input logic [W-1:0] exp_min,
                          input logic [W-1:0] exp_max);
    int lat;
    accept_pair(tag, a, b);
    wait_result(lat);
    chk({tag, "_latency"}, W'(lat), W'(W));
    chk({tag, "_lteq"}, {31'd0, out_lteq}, {31'd0, exp_l});
    chk({tag, "_min"}, out_min, exp_min);
    chk({tag, "_max"}, out_max, exp_max);
    tick();
  endtask

  initial begin
    int lat;
    int cyc;
    int results;
    int last_acc;
    logic acc;
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
    logic [W-1:0] hold_min;
    logic [W-1:0] hold_max;
    logic exp_l;

    n_vec     = 0;
    n_miss    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    exp_a     = '0;
    exp_b     = '0;

    // Reset state
    repeat (2) tick();
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_lteq", {31'd0, out_lteq}, 0);
    chk("rst_out_min", out_min, 0);
    chk("rst_out_max", out_max, 0);
    rst_n = 1'b1;
    tick();

    // Directed pairs
    run_pair("neg1_vs_0", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000);
    run_pair("maxpos_vs_minneg", 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'h8000_0000,
             32'h7FFF_FFFF);
    run_pair("equal", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h1234_5678, 32'h1234_5678);
    run_pair("5_vs_6", 32'd5, 32'd6, 1'b1, 32'd5, 32'd6);
    run_pair("6_vs_5", 32'd6, 32'd5, 1'b0, 32'd5, 32'd6);
    run_pair("minneg_vs_neg1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000,
             32'hFFFF_FFFF);

    // Backpressure: 16 vs -16, with a stray pair offered during SHIFT and DONE
    out_ready = 1'b0;
    accept_pair("bp", 32'h0000_0010, 32'hFFFF_FFF0);
    repeat (3) tick();
    in_valid = 1'b1;
    in_a     = 32'd1;
    in_b     = 32'd2;
    repeat (3) tick();
    chk("bp_shift_in_ready", {31'd0, in_ready}, 0);
    in_valid = 1'b0;
    wait_result(lat);
    chk("bp_latency", W'(lat + 6), W'(W));
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", {31'd0, out_valid}, 1);
      chk("bp_hold_in_ready", {31'd0, in_ready}, 0);
      chk("bp_hold_lteq", {31'd0, out_lteq}, 0);
      chk("bp_hold_min", out_min, 32'hFFFF_FFF0);
      chk("bp_hold_max", out_max, 32'h0000_0010);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", {31'd0, out_valid}, 0);
    chk("bp_release_in_ready", {31'd0, in_ready}, 1);
    chk("bp_persist_min", out_min, 32'hFFFF_FFF0);
    repeat (WIDTH_GAP()) tick();
    chk("bp_no_capture_valid", {31'd0, out_valid}, 0);
    chk("bp_no_capture_ready", {31'd0, in_ready}, 1);

    // Reset in the middle of a scan
    accept_pair("rst_mid", 32'd3, 32'd9);
    repeat (15) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, out_valid}, 0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 1);
    tick();
    rst_n = 1'b1;
    repeat (W + 4) tick();
    chk("rst_mid_no_result", {31'd0, out_valid}, 0);
    run_pair("neg2_vs_neg3", 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFE);

    // Random pairs, back-to-back in_valid; first phase checks throughput
    in_valid = 1'b1;
    in_a     = $urandom;
    in_b     = $urandom;
    results  = 0;
    cyc      = 0;
    last_acc = -1;
    while (results < 170 && cyc < 20000) begin
      out_ready = (results < 20) ? 1'b1 : 1'($urandom_range(0, 1));
      acc = in_ready && in_valid;
      if (out_valid && out_ready) begin
        exp_l    = ref_lteq(exp_a, exp_b);
        hold_min = exp_l ? exp_a : exp_b;
        hold_max = exp_l ? exp_b : exp_a;
        chk("rand_lteq", {31'd0, out_lteq}, {31'd0, exp_l});
        chk("rand_min", out_min, hold_min);
        chk("rand_max", out_max, hold_max);
        results++;
      end
      if (acc) begin
        exp_a = in_a;
        exp_b = in_b;
        if (results < 20 && last_acc >= 0) chk("rand_throughput", W'(cyc - last_acc), W'(W + 2));
        last_acc = cyc;
      end
      tick();
      cyc++;
      if (acc) begin
        in_a = $urandom;
        in_b = $urandom;
      end
    end
    chk("rand_result_count", W'(results), W'(170));
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  function automatic int WIDTH_GAP();
    return 3;
  endfunction

endmodule
